// File: rtl/accum_arbiter_pkg.sv
// Shared encodings for the two-requester accumulator: FSM states and op select values.
package accum_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b1;
    localparam logic OP_SUB = 1'b0;

endpackage

// File: rtl/accum_arbiter_rr.sv
// Two-way round-robin arbiter; pointer holds the index of the requester served last.
module rr_arbiter_2
    import accum_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       aclr,
    input  logic       req0,
    input  logic       req1,
    input  logic       enable,
    output logic [1:0] grant,
    output logic       pointer
);

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            // On a tie the requester not served last wins.
            if (req0 && req1) grant = pointer ? 2'b01 : 2'b10;
            else              grant = {req1, req0};
        end
    end

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr)        pointer <= 1'b1;
        else if (|grant)  pointer <= grant[1];
    end

endmodule

// File: rtl/accum_arbiter.sv
// Accumulator shared by two requesters: IDLE grants one op, EXEC computes, DONE reports.
module accum_arbiter
    import accum_arbiter_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         aclr,
    input  logic         clr,
    input  logic         req0,
    input  logic         req1,
    input  logic         op0,
    input  logic         op1,
    input  logic [N-1:0] a0,
    input  logic [N-1:0] a1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         busy,
    output logic         done,
    output logic         done_id,
    output logic [N-1:0] S,
    output logic         carry,
    output logic         overflow
);

    state_t       state, state_nx;
    logic [1:0]   grant;
    logic         pointer;
    logic         arb_en;
    logic [N-1:0] b_p1;
    logic         op_p1;
    logic [N+1:0] alu_res;

    // Returns {overflow, carry/borrow, result} for S op b in N+1 bits.
    function automatic logic [N+1:0] alu_f(input logic [N-1:0] s, input logic [N-1:0] b,
                                           input logic op);
        logic [N:0]   r;
        logic [N-1:0] bp;
        bp = (op == OP_ADD) ? b : ~b;
        r  = (op == OP_ADD) ? ({1'b0, s} + {1'b0, b}) : ({1'b0, s} - {1'b0, b});
        return {(s[N-1] == bp[N-1]) && (r[N-1] != s[N-1]), r};
    endfunction

    assign arb_en  = (state == IDLE) && !clr;
    assign alu_res = alu_f(S, b_p1, op_p1);

    rr_arbiter_2 u_arb (
        .clk     (clk),
        .aclr    (aclr),
        .req0    (req0),
        .req1    (req1),
        .enable  (arb_en),
        .grant   (grant),
        .pointer (pointer)
    );

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) state <= IDLE;
        else       state <= state_nx;
    end

    // The pointer only moves on a grant, so during EXEC/DONE it names the requester in flight.
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        done     = 1'b0;
        done_id  = 1'b0;
        case (state)
            IDLE: if (|grant) state_nx = EXEC;
            EXEC: begin
                state_nx = DONE;
                busy     = 1'b1;
                gnt0     = !pointer;
                gnt1     = pointer;
            end
            DONE: begin
                state_nx = IDLE;
                busy     = 1'b1;
                done     = 1'b1;
                done_id  = pointer;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operand capture on the granting edge (p1 = EXEC stage), result on the edge leaving EXEC.
    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            S        <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            b_p1     <= '0;
            op_p1    <= 1'b0;
        end else if ((state == IDLE) && clr) begin
            S        <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
        end else if (|grant) begin
            b_p1  <= grant[1] ? a1 : a0;
            op_p1 <= grant[1] ? op1 : op0;
        end else if (state == EXEC) begin
            overflow   <= alu_res[N+1];
            {carry, S} <= alu_res[N:0];
        end
    end

endmodule

// File: tb/tb_accum_arbiter.sv
// Directed bench for accum_arbiter (N=8) with hand-computed expectations.
module tb_accum_arbiter;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         aclr, clr, req0, req1, op0, op1;
    logic [N-1:0] a0, a1;
    logic         gnt0, gnt1, busy, done, done_id, carry, overflow;
    logic [N-1:0] S;

    int total = 0;
    int bad   = 0;

    // Arithmetic table for requester 1: op, operand, expected {carry, overflow, S}.
    logic       tab_op  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [7:0] tab_a   [7] = '{8'h7F, 8'h01, 8'h7F, 8'h01, 8'h01, 8'h7F, 8'h01};
    logic [9:0] tab_exp [7] = '{{2'b00, 8'h7F}, {2'b01, 8'h80}, {2'b00, 8'hFF},
                                {2'b10, 8'h00}, {2'b10, 8'hFF}, {2'b00, 8'h80},
                                {2'b01, 8'h7F}};

    accum_arbiter #(.N(N)) dut (
        .clk      (clk),
        .aclr     (aclr),
        .clr      (clr),
        .req0     (req0),
        .req1     (req1),
        .op0      (op0),
        .op1      (op1),
        .a0       (a0),
        .a1       (a1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .busy     (busy),
        .done     (done),
        .done_id  (done_id),
        .S        (S),
        .carry    (carry),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        aclr = 1'b0; clr = 1'b0; req0 = 1'b0; req1 = 1'b0;
        op0 = 1'b0; op1 = 1'b0; a0 = '0; a1 = '0;
        #3;
        total++;
        if ({gnt0, gnt1, busy, done, done_id, carry, overflow, S} !== 15'b0) begin
            bad++;
            $display("FAIL reset_outputs: got %b want %b",
                     {gnt0, gnt1, busy, done, done_id, carry, overflow, S}, 15'b0);
        end
        #9;
        aclr = 1'b1;
        tick;
        total++;
        if ({busy, gnt0, gnt1, done} !== 4'b0) begin
            bad++;
            $display("FAIL reset_idle: got %b want 0000", {busy, gnt0, gnt1, done});
        end
    endtask

    task automatic test_single_add;
        req0 = 1'b1; op0 = 1'b1; a0 = 8'h05;
        tick;
        total++;
        if ({gnt0, gnt1, busy, done} !== 4'b1010) begin
            bad++;
            $display("FAIL single_grant: got %b want 1010", {gnt0, gnt1, busy, done});
        end
        req0 = 1'b0; a0 = '0;
        tick;
        total++;
        if ({done, done_id, busy, carry, overflow, S} !== {5'b10100, 8'h05}) begin
            bad++;
            $display("FAIL single_done: got %b want %b",
                     {done, done_id, busy, carry, overflow, S}, {5'b10100, 8'h05});
        end
        tick;
        total++;
        if ({busy, done, gnt0, gnt1} !== 4'b0) begin
            bad++;
            $display("FAIL single_idle: got %b want 0000", {busy, done, gnt0, gnt1});
        end
    endtask

    task automatic test_arith;
        clr = 1'b1;
        tick;
        clr = 1'b0;
        total++;
        if ({carry, overflow, S} !== 10'b0) begin
            bad++;
            $display("FAIL arith_clr: got %h want 000", {carry, overflow, S});
        end
        for (int i = 0; i < 7; i++) begin
            req1 = 1'b1; op1 = tab_op[i]; a1 = tab_a[i];
            tick;
            total++;
            if ({gnt0, gnt1} !== 2'b01) begin
                bad++;
                $display("FAIL arith_grant[%0d]: got %b want 01", i, {gnt0, gnt1});
            end
            req1 = 1'b0;
            tick;
            total++;
            if ({done, done_id, carry, overflow, S} !== {2'b11, tab_exp[i]}) begin
                bad++;
                $display("FAIL arith_result[%0d]: got %b want %b", i,
                         {done, done_id, carry, overflow, S}, {2'b11, tab_exp[i]});
            end
            tick;
            total++;
            if ({busy, carry, overflow, S} !== {1'b0, tab_exp[i]}) begin
                bad++;
                $display("FAIL arith_hold[%0d]: got %b want %b", i,
                         {busy, carry, overflow, S}, {1'b0, tab_exp[i]});
            end
        end
    endtask

    task automatic test_tie;
        clr = 1'b1;
        tick;
        clr = 1'b0;
        req0 = 1'b1; op0 = 1'b1; a0 = 8'h10;
        req1 = 1'b1; op1 = 1'b0; a1 = 8'h03;
        tick;
        total++;
        if ({gnt0, gnt1} !== 2'b10) begin
            bad++;
            $display("FAIL tie_first_grant: got %b want 10", {gnt0, gnt1});
        end
        req0 = 1'b0;
        tick;
        total++;
        if ({done, done_id, S} !== {2'b10, 8'h10}) begin
            bad++;
            $display("FAIL tie_first_done: got %b want %b", {done, done_id, S}, {2'b10, 8'h10});
        end
        tick;
        total++;
        if ({busy, gnt0, gnt1} !== 3'b000) begin
            bad++;
            $display("FAIL tie_gap_idle: got %b want 000", {busy, gnt0, gnt1});
        end
        tick;
        total++;
        if ({gnt0, gnt1} !== 2'b01) begin
            bad++;
            $display("FAIL tie_second_grant: got %b want 01", {gnt0, gnt1});
        end
        req1 = 1'b0;
        tick;
        total++;
        if ({done, done_id, carry, overflow, S} !== {4'b1100, 8'h0D}) begin
            bad++;
            $display("FAIL tie_second_done: got %b want %b",
                     {done, done_id, carry, overflow, S}, {4'b1100, 8'h0D});
        end
        tick;
    endtask

    task automatic test_back_to_back;
        req0 = 1'b1; op0 = 1'b1; a0 = 8'h01;
        req1 = 1'b1; op1 = 1'b1; a1 = 8'h01;
        tick;
        total++;
        if ({gnt0, gnt1} !== 2'b10) begin
            bad++;
            $display("FAIL b2b_grant_a: got %b want 10", {gnt0, gnt1});
        end
        tick;
        total++;
        if ({done, done_id, S} !== {2'b10, 8'h0E}) begin
            bad++;
            $display("FAIL b2b_done_a: got %b want %b", {done, done_id, S}, {2'b10, 8'h0E});
        end
        tick;
        tick;
        total++;
        if ({gnt0, gnt1} !== 2'b01) begin
            bad++;
            $display("FAIL b2b_grant_b: got %b want 01", {gnt0, gnt1});
        end
        req1 = 1'b0;
        tick;
        total++;
        if ({done, done_id, S} !== {2'b11, 8'h0F}) begin
            bad++;
            $display("FAIL b2b_done_b: got %b want %b", {done, done_id, S}, {2'b11, 8'h0F});
        end
        tick;
        tick;
        total++;
        if ({gnt0, gnt1} !== 2'b10) begin
            bad++;
            $display("FAIL b2b_grant_c: got %b want 10", {gnt0, gnt1});
        end
        req0 = 1'b0;
        tick;
        total++;
        if ({done, done_id, S} !== {2'b10, 8'h10}) begin
            bad++;
            $display("FAIL b2b_done_c: got %b want %b", {done, done_id, S}, {2'b10, 8'h10});
        end
        tick;
    endtask

    task automatic test_clr_priority;
        clr = 1'b1;
        tick;
        clr = 1'b0;
        req0 = 1'b1; op0 = 1'b1; a0 = 8'h42;
        tick;
        req0 = 1'b0;
        tick;
        total++;
        if (S !== 8'h42) begin
            bad++;
            $display("FAIL clr_setup: got %h want 42", S);
        end
        tick;
        clr = 1'b1; req0 = 1'b1; a0 = 8'h01;
        tick;
        total++;
        if ({gnt0, gnt1, busy, S} !== {3'b000, 8'h00}) begin
            bad++;
            $display("FAIL clr_priority: got %b want %b", {gnt0, gnt1, busy, S}, 11'b0);
        end
        clr = 1'b0;
        tick;
        total++;
        if ({gnt0, gnt1} !== 2'b10) begin
            bad++;
            $display("FAIL clr_then_grant: got %b want 10", {gnt0, gnt1});
        end
        req0 = 1'b0;
        tick;
        total++;
        if ({done, done_id, S} !== {2'b10, 8'h01}) begin
            bad++;
            $display("FAIL clr_then_done: got %b want %b", {done, done_id, S}, {2'b10, 8'h01});
        end
        tick;
    endtask

    task automatic test_aclr_abort;
        req0 = 1'b1; op0 = 1'b1; a0 = 8'h33;
        tick;
        total++;
        if ({gnt0, gnt1} !== 2'b10) begin
            bad++;
            $display("FAIL abort_grant: got %b want 10", {gnt0, gnt1});
        end
        req0 = 1'b0;
        aclr = 1'b0;
        #1;
        total++;
        if ({gnt0, gnt1, busy, done, done_id, carry, overflow, S} !== 15'b0) begin
            bad++;
            $display("FAIL abort_outputs: got %b want %b",
                     {gnt0, gnt1, busy, done, done_id, carry, overflow, S}, 15'b0);
        end
        @(posedge clk);
        #3;
        aclr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            total++;
            if ({done, busy, S} !== 10'b0) begin
                bad++;
                $display("FAIL abort_no_done[%0d]: got %b want 0", i, {done, busy, S});
            end
        end
        req0 = 1'b1; op0 = 1'b1; a0 = 8'h01;
        req1 = 1'b1; op1 = 1'b1; a1 = 8'h02;
        tick;
        total++;
        if ({gnt0, gnt1} !== 2'b10) begin
            bad++;
            $display("FAIL abort_tie_grant: got %b want 10", {gnt0, gnt1});
        end
        req0 = 1'b0;
        tick;
        total++;
        if ({done, done_id, S} !== {2'b10, 8'h01}) begin
            bad++;
            $display("FAIL abort_tie_done0: got %b want %b", {done, done_id, S}, {2'b10, 8'h01});
        end
        tick;
        tick;
        total++;
        if ({gnt0, gnt1} !== 2'b01) begin
            bad++;
            $display("FAIL abort_tie_grant1: got %b want 01", {gnt0, gnt1});
        end
        req1 = 1'b0;
        tick;
        total++;
        if ({done, done_id, S} !== {2'b11, 8'h03}) begin
            bad++;
            $display("FAIL abort_tie_done1: got %b want %b", {done, done_id, S}, {2'b11, 8'h03});
        end
        tick;
    endtask

    initial begin
        test_reset;
        test_single_add;
        test_arith;
        test_tie;
        test_back_to_back;
        test_clr_priority;
        test_aclr_abort;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
